// File: rtl/tensor_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tensor_regfile_pkg                                                   |
// | Shared sizing helpers, register indices and address composition.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tensor_regfile_pkg;

  localparam int LANE_W   = 18;
  localparam int THREAD_W = 1;
  localparam int INDEX_W  = 5;

  localparam int unsigned REG_MATMUL_INPUT  = 0;
  localparam int unsigned REG_MATMUL_OUTPUT = 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  function automatic int word_w(input int sz);
    return sz * sz * LANE_W;
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Entries are addressed as {superscalar_thread, register index}.
  function automatic logic [THREAD_W+INDEX_W-1:0] reg_addr(
    input logic [THREAD_W-1:0] thread,
    input logic [INDEX_W-1:0]  index
  );
    return {thread, index};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tensor_regfile_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_clear_seq                                                    |
// | Post-reset zeroing sweep sequencer; overrides client writes.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_clear_seq
  import tensor_regfile_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  clr_state_e    state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = ptr;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_nx = ST_RUN;
          ptr_nx   = '0;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tensor_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tensor_regfile                                                       |
// | Two-read/two-write tensor register file with bypass and clear sweep. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tensor_regfile
  import tensor_regfile_pkg::*;
#(
  parameter int SZ    = 4,
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        freeze,
  output logic                        busy,
  input  logic [addr_w(DEPTH)-1:0]    rd0_addr,
  output logic [word_w(SZ)-1:0]       rd0_dat,
  input  logic [addr_w(DEPTH)-1:0]    rd1_addr,
  output logic [word_w(SZ)-1:0]       rd1_dat,
  input  logic                        wr0_we,
  input  logic [addr_w(DEPTH)-1:0]    wr0_addr,
  input  logic [word_w(SZ)-1:0]       wr0_dat,
  input  logic                        wr1_we,
  input  logic [addr_w(DEPTH)-1:0]    wr1_addr,
  input  logic [word_w(SZ)-1:0]       wr1_dat
);

  localparam int W  = word_w(SZ);
  localparam int AW = addr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr0_go, wr1_go;

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // wr1 is dropped outright on a collision so the bypass sees only real commits.
  assign wr0_go = wr0_we && !busy && !reset;
  assign wr1_go = wr1_we && !busy && !reset && !(wr0_we && wr0_addr == wr1_addr);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr1_go) mem[wr1_addr] <= wr1_dat;
      if (wr0_go) mem[wr0_addr] <= wr0_dat;
    end
  end

  logic [AW-1:0] rd_addr [2];
  logic [W-1:0]  rd_q    [2];

  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;
  assign rd0_dat    = rd_q[0];
  assign rd1_dat    = rd_q[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [W-1:0] rd_next;

    always_comb begin
      rd_next = mem[rd_addr[p]];
      if (wr1_go && wr1_addr == rd_addr[p]) rd_next = wr1_dat;
      if (wr0_go && wr0_addr == rd_addr[p]) rd_next = wr0_dat;
    end

    always_ff @(posedge clk) begin
      if (reset || busy) begin
        rd_q[p] <= '0;
      end else if (!freeze) begin
        rd_q[p] <= rd_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tensor_regfile.sv
`default_nettype none
// Directed table-driven bench for tensor_regfile at default parameters.
module tb_tensor_regfile;

  localparam int W  = 288;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset, freeze, busy;
  logic [AW-1:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr;
  logic [W-1:0]  rd0_dat, rd1_dat, wr0_dat, wr1_dat;
  logic          wr0_we, wr1_we;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tensor_regfile #(.SZ(4), .DEPTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .freeze   (freeze),
    .busy     (busy),
    .rd0_addr (rd0_addr),
    .rd0_dat  (rd0_dat),
    .rd1_addr (rd1_addr),
    .rd1_dat  (rd1_dat),
    .wr0_we   (wr0_we),
    .wr0_addr (wr0_addr),
    .wr0_dat  (wr0_dat),
    .wr1_we   (wr1_we),
    .wr1_addr (wr1_addr),
    .wr1_dat  (wr1_dat)
  );

  typedef struct {
    logic          w0_we;
    logic [AW-1:0] w0_a;
    logic [W-1:0]  w0_d;
    logic          w1_we;
    logic [AW-1:0] w1_a;
    logic [W-1:0]  w1_d;
    logic [AW-1:0] r0_a;
    logic [AW-1:0] r1_a;
    logic          frz;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [W-1:0] lanev(input int i, input logic [17:0] v);
    logic [W-1:0] r;
    r = '0;
    r[18*i +: 18] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    freeze = 1'b0; wr0_we = 1'b0; wr1_we = 1'b0;
    wr0_addr = '0; wr1_addr = '0; wr0_dat = '0; wr1_dat = '0;
    rd0_addr = '0; rd1_addr = '0;
  endtask

  // Counts edges until busy drops; optionally drives a wr0 write to addr 3 and freeze throughout.
  task automatic sweep_len(input logic poke, output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (poke) begin
        wr0_we = 1'b1; wr0_addr = 6'd3; wr0_dat = lanev(2, 18'h1234); freeze = 1'b1;
      end
      step();
      n++;
    end
    idle_inputs();
  endtask

  logic [W-1:0] D5, A, B, C, E, F, G, C2;
  int n;

  initial begin
    D5 = lanev(0, 18'h3FFFF);
    A  = lanev(1, 18'h0AAAA) | lanev(3, 18'h15555);
    B  = lanev(1, 18'h12345) | lanev(14, 18'h00001);
    C  = lanev(5, 18'h2BEEF);
    E  = lanev(8, 18'h1F00F);
    F  = lanev(6, 18'h00777);
    G  = lanev(15, 18'h2AAAA);
    C2 = lanev(9, 18'h3C3C3);

    //          w0we w0a   w0d  w1we w1a   w1d  r0a   r1a   frz  e0  e1
    vecs[0] = '{1'b1, 6'd5,  D5, 1'b0, 6'd0,  '0, 6'd5,  6'd5,  1'b0, D5, D5};
    vecs[1] = '{1'b0, 6'd0,  '0, 1'b0, 6'd0,  '0, 6'd5,  6'd4,  1'b0, D5, '0};
    vecs[2] = '{1'b1, 6'd9,  A,  1'b1, 6'd9,  B,  6'd5,  6'd9,  1'b0, D5, A };
    vecs[3] = '{1'b0, 6'd0,  '0, 1'b0, 6'd0,  '0, 6'd9,  6'd9,  1'b0, A,  A };
    vecs[4] = '{1'b1, 6'd11, C,  1'b1, 6'd10, B,  6'd10, 6'd11, 1'b0, B,  C };
    vecs[5] = '{1'b0, 6'd0,  '0, 1'b0, 6'd0,  '0, 6'd11, 6'd10, 1'b0, C,  B };
    vecs[6] = '{1'b0, 6'd0,  '0, 1'b1, 6'd12, E,  6'd5,  6'd12, 1'b0, D5, E };
    vecs[7] = '{1'b1, 6'd6,  F,  1'b0, 6'd0,  '0, 6'd6,  6'd9,  1'b1, D5, E };
    vecs[8] = '{1'b0, 6'd0,  '0, 1'b0, 6'd0,  '0, 6'd6,  6'd12, 1'b0, F,  E };
    vecs[9] = '{1'b1, 6'd7,  G,  1'b0, 6'd0,  '0, 6'd7,  6'd63, 1'b0, G,  '0};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("reset_busy", W'(busy), W'(1));
    chk("reset_rd0", rd0_dat, '0);
    chk("reset_rd1", rd1_dat, '0);

    // First sweep: wr0 to addr 3 and freeze held high the whole time.
    reset = 1'b0;
    sweep_len(1'b1, n);
    chk("sweep1_len", W'(n), W'(64));
    for (int i = 0; i < 64; i++) begin
      rd0_addr = AW'(i);
      rd1_addr = AW'(63 - i);
      step();
      chk($sformatf("zero_rd0_%0d", i), rd0_dat, '0);
      chk($sformatf("zero_rd1_%0d", 63 - i), rd1_dat, '0);
    end

    for (int v = 0; v < 10; v++) begin
      wr0_we = vecs[v].w0_we; wr0_addr = vecs[v].w0_a; wr0_dat = vecs[v].w0_d;
      wr1_we = vecs[v].w1_we; wr1_addr = vecs[v].w1_a; wr1_dat = vecs[v].w1_d;
      rd0_addr = vecs[v].r0_a; rd1_addr = vecs[v].r1_a; freeze = vecs[v].frz;
      step();
      chk($sformatf("vec%0d_rd0", v), rd0_dat, vecs[v].e0);
      chk($sformatf("vec%0d_rd1", v), rd1_dat, vecs[v].e1);
    end
    idle_inputs();

    // Freeze for three cycles while the read address walks 5 -> 6 -> 7.
    rd0_addr = 6'd5;
    step();
    chk("frz_pre", rd0_dat, D5);
    freeze = 1'b1;
    rd0_addr = 6'd6; step(); chk("frz_hold1", rd0_dat, D5);
    rd0_addr = 6'd7; step(); chk("frz_hold2", rd0_dat, D5);
    step();                  chk("frz_hold3", rd0_dat, D5);
    freeze = 1'b0;
    step();
    chk("frz_release", rd0_dat, G);

    // Write addr 12, then reset again 10 cycles into a fresh sweep.
    wr0_we = 1'b1; wr0_addr = 6'd12; wr0_dat = C2;
    step();
    idle_inputs();
    rd1_addr = 6'd12;
    step();
    chk("wr12_read", rd1_dat, C2);
    reset = 1'b1;
    step();
    chk("reset2_rd1", rd1_dat, '0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("midsweep_busy", W'(busy), W'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_len(1'b0, n);
    chk("sweep2_len", W'(n), W'(64));
    rd0_addr = 6'd12; rd1_addr = 6'd9;
    step();
    chk("after_reset_rd12", rd0_dat, '0);
    chk("after_reset_rd9", rd1_dat, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
